// File: rtl/decode_stage_pipelined_if.sv
// IF/ID-side inputs, WB/EX-MEM hazard inputs and the ID/EX register outputs of the decode stage.
// master drives instructions and write-back traffic; slave is the decode stage itself.
interface decode_stage_pipelined_if #(
  parameter int N_BITS     = 32,
  parameter int N_REG_BITS = 5
);
  logic                  i_valid;
  logic [N_BITS-1:0]     i_instruccion;
  logic [N_BITS-1:0]     i_pc_4;
  logic                  i_flush;
  logic                  i_wb_regWrite;
  logic [N_REG_BITS-1:0] i_wb_addr;
  logic [N_BITS-1:0]     i_wb_data;
  logic                  i_exmem_regWrite;
  logic [N_REG_BITS-1:0] i_exmem_dst;

  logic                  o_stall;
  logic                  o_branch_taken;
  logic [N_BITS-1:0]     o_DstSalto;
  logic                  o_halt;
  logic                  o_valid;
  logic [N_BITS-1:0]     o_dato_leido1;
  logic [N_BITS-1:0]     o_dato_leido2;
  logic [N_BITS-1:0]     o_dato_ex_signo;
  logic [N_BITS-1:0]     o_pc_4;
  logic [N_REG_BITS-1:0] o_rs;
  logic [N_REG_BITS-1:0] o_rt;
  logic [N_REG_BITS-1:0] o_rd_or_rt;
  logic                  o_control_WB_memtoReg;
  logic                  o_control_WB_regWrite;
  logic                  o_control_M_memWrite;
  logic                  o_control_M_memRead;
  logic                  o_control_EX_ALUSrc;
  logic [1:0]            o_control_EX_ALUOp;

  modport master (
    output i_valid, i_instruccion, i_pc_4, i_flush,
           i_wb_regWrite, i_wb_addr, i_wb_data, i_exmem_regWrite, i_exmem_dst,
    input  o_stall, o_branch_taken, o_DstSalto, o_halt, o_valid,
           o_dato_leido1, o_dato_leido2, o_dato_ex_signo, o_pc_4,
           o_rs, o_rt, o_rd_or_rt,
           o_control_WB_memtoReg, o_control_WB_regWrite, o_control_M_memWrite,
           o_control_M_memRead, o_control_EX_ALUSrc, o_control_EX_ALUOp
  );

  modport slave (
    input  i_valid, i_instruccion, i_pc_4, i_flush,
           i_wb_regWrite, i_wb_addr, i_wb_data, i_exmem_regWrite, i_exmem_dst,
    output o_stall, o_branch_taken, o_DstSalto, o_halt, o_valid,
           o_dato_leido1, o_dato_leido2, o_dato_ex_signo, o_pc_4,
           o_rs, o_rt, o_rd_or_rt,
           o_control_WB_memtoReg, o_control_WB_regWrite, o_control_M_memWrite,
           o_control_M_memRead, o_control_EX_ALUSrc, o_control_EX_ALUOp
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// MIPS ID stage: regfile, control decode, hazards, branch resolve; ID/EX is 1 cycle after accept.
// Backpressure: o_stall holds PC/IF-ID combinationally while ID/EX takes a bubble; halt stalls forever.
module decode_stage_pipelined #(
  parameter int N_BITS     = 32,
  parameter int N_REG_BITS = 5,
  parameter int BYPASS_EN  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  decode_stage_pipelined_if.slave bus
);

  localparam int N_REGS = 2 ** N_REG_BITS;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef struct packed {
    logic       known;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       dst_rd;
    logic       use_rs;
    logic       use_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_halt;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [N_BITS-1:0]     rd1;
    logic [N_BITS-1:0]     rd2;
    logic [N_BITS-1:0]     imm_ext;
    logic [N_BITS-1:0]     pc_4;
    logic [N_REG_BITS-1:0] rs;
    logic [N_REG_BITS-1:0] rt;
    logic [N_REG_BITS-1:0] dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  alu_src;
    logic [1:0]            alu_op;
  } idex_t;

  // Field positions are fixed by the 32-bit MIPS encoding regardless of N_BITS.
  logic [31:0]           instr32;
  logic [5:0]            opcode;
  logic [N_REG_BITS-1:0] rs;
  logic [N_REG_BITS-1:0] rt;
  logic [N_REG_BITS-1:0] rd;
  logic [15:0]           imm;
  logic [N_BITS-1:0]     imm_ext;

  assign instr32 = 32'(bus.i_instruccion);
  assign opcode  = instr32[31:26];
  assign rs      = N_REG_BITS'(instr32[25:21]);
  assign rt      = N_REG_BITS'(instr32[20:16]);
  assign rd      = N_REG_BITS'(instr32[15:11]);
  assign imm     = instr32[15:0];
  assign imm_ext = {{(N_BITS-16){imm[15]}}, imm};

  ctrl_t dec;

  always_comb begin
    dec        = '0;
    dec.use_rs = (opcode != OP_HALT);
    case (opcode)
      OP_RTYPE: begin
        dec.known     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.dst_rd    = 1'b1;
        dec.use_rt    = 1'b1;
      end
      OP_ADDI: begin
        dec.known     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LW: begin
        dec.known      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec.known     = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.use_rt    = 1'b1;
      end
      OP_BEQ: begin
        dec.known  = 1'b1;
        dec.alu_op = 2'b01;
        dec.use_rt = 1'b1;
        dec.is_beq = 1'b1;
      end
      OP_BNE: begin
        dec.known  = 1'b1;
        dec.alu_op = 2'b01;
        dec.use_rt = 1'b1;
        dec.is_bne = 1'b1;
      end
      OP_HALT: begin
        dec.known   = 1'b1;
        dec.is_halt = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file: entry 0 is never written and is forced to read zero.
  logic [N_BITS-1:0] rf [N_REGS];
  logic              wb_we;
  logic [N_BITS-1:0] rd1;
  logic [N_BITS-1:0] rd2;

  assign wb_we = bus.i_wb_regWrite && (bus.i_wb_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rf <= '{default: '0};
    end else if (wb_we) begin
      rf[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  always_comb begin
    rd1 = rf[rs];
    if (rs == '0) begin
      rd1 = '0;
    end else if ((BYPASS_EN != 0) && wb_we && (bus.i_wb_addr == rs)) begin
      rd1 = bus.i_wb_data;
    end
  end

  always_comb begin
    rd2 = rf[rt];
    if (rt == '0) begin
      rd2 = '0;
    end else if ((BYPASS_EN != 0) && wb_we && (bus.i_wb_addr == rt)) begin
      rd2 = bus.i_wb_data;
    end
  end

  idex_t idex_q;
  idex_t idex_d;
  logic  halt_q;

  logic load_use;
  logic rs_pending;
  logic rt_pending;
  logic branch_stall;
  logic stall;
  logic accept;
  logic taken;

  assign load_use = bus.i_valid && idex_q.valid && idex_q.mem_read && (idex_q.dst != '0) &&
                    ((dec.use_rs && (rs == idex_q.dst)) || (dec.use_rt && (rt == idex_q.dst)));

  // A branch compares in ID, so any producer still in EX or MEM must drain first.
  assign rs_pending = (rs != '0) &&
                      ((idex_q.valid && idex_q.reg_write && (rs == idex_q.dst)) ||
                       (bus.i_exmem_regWrite && (bus.i_exmem_dst == rs)));
  assign rt_pending = (rt != '0) &&
                      ((idex_q.valid && idex_q.reg_write && (rt == idex_q.dst)) ||
                       (bus.i_exmem_regWrite && (bus.i_exmem_dst == rt)));

  assign branch_stall = (dec.is_beq || dec.is_bne) && (rs_pending || rt_pending);
  assign stall        = load_use || branch_stall || halt_q;
  assign accept       = bus.i_valid && !stall && !bus.i_flush;
  assign taken        = accept && ((dec.is_beq && (rd1 == rd2)) || (dec.is_bne && (rd1 != rd2)));

  always_comb begin
    idex_d = '0;
    if (accept && dec.known) begin
      idex_d.valid      = 1'b1;
      idex_d.rd1        = rd1;
      idex_d.rd2        = rd2;
      idex_d.imm_ext    = imm_ext;
      idex_d.pc_4       = bus.i_pc_4;
      idex_d.rs         = rs;
      idex_d.rt         = rt;
      idex_d.dst        = dec.dst_rd ? rd : rt;
      idex_d.mem_to_reg = dec.mem_to_reg;
      idex_d.reg_write  = dec.reg_write;
      idex_d.mem_write  = dec.mem_write;
      idex_d.mem_read   = dec.mem_read;
      idex_d.alu_src    = dec.alu_src;
      idex_d.alu_op     = dec.alu_op;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_q <= '0;
      halt_q <= 1'b0;
    end else begin
      idex_q <= idex_d;
      if (accept && dec.is_halt) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign bus.o_stall               = stall;
  assign bus.o_branch_taken        = taken;
  assign bus.o_DstSalto            = bus.i_pc_4 + (imm_ext << 2);
  assign bus.o_halt                = halt_q;
  assign bus.o_valid               = idex_q.valid;
  assign bus.o_dato_leido1         = idex_q.rd1;
  assign bus.o_dato_leido2         = idex_q.rd2;
  assign bus.o_dato_ex_signo       = idex_q.imm_ext;
  assign bus.o_pc_4                = idex_q.pc_4;
  assign bus.o_rs                  = idex_q.rs;
  assign bus.o_rt                  = idex_q.rt;
  assign bus.o_rd_or_rt            = idex_q.dst;
  assign bus.o_control_WB_memtoReg = idex_q.mem_to_reg;
  assign bus.o_control_WB_regWrite = idex_q.reg_write;
  assign bus.o_control_M_memWrite  = idex_q.mem_write;
  assign bus.o_control_M_memRead   = idex_q.mem_read;
  assign bus.o_control_EX_ALUSrc   = idex_q.alu_src;
  assign bus.o_control_EX_ALUOp    = idex_q.alu_op;

endmodule
